// File: rtl/stream_lane_packer_if.sv
// Handshake bundle between the lane-producing datapath, stream_lane_packer and the AXI4-Stream sink.
// Latency: none; this is wiring only.
// Backpressure: carries in_valid/in_ready on the lane side and out_valid/out_ready on the AXI side.
//
// Signals:
//   in_valid, in_ready     input beat handshake
//   in_data                packed lanes, lane i = in_data[i]
//   in_lane_en             per-lane enable, any pattern including all-zero
//   in_last                final input beat of a packet
//   out_ready              AXI sink ready
//   out_data, out_keep     densely packed output lanes and contiguous byte enables
//   out_valid, out_last    AXI beat valid and packet end
// Modports: master = lane producer / AXI consumer side; slave = the packer itself.
interface stream_lane_packer_if #(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = 128
);
  localparam int OUT_W  = NUM_LANES * LANE_W;
  localparam int KEEP_W = OUT_W / 8;

  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_LANES-1:0][LANE_W-1:0] in_data;
  logic [NUM_LANES-1:0]             in_lane_en;
  logic                             in_last;
  logic                             out_ready;
  logic [OUT_W-1:0]                 out_data;
  logic [KEEP_W-1:0]                out_keep;
  logic                             out_valid;
  logic                             out_last;

  modport master (
    output in_valid, in_data, in_lane_en, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_data, in_lane_en, in_last, out_ready,
    output in_ready, out_data, out_keep, out_valid, out_last
  );
endinterface

// File: rtl/stream_lane_packer.sv
// Compacts lane-enabled input beats into densely packed AXI4-Stream beats, carrying partial residue across beats.
// Latency: 1 cycle from input accept to out_valid (registered output stage).
// Backpressure: in_ready drops while a stalled output is held or a flush beat is pending; output is held stable until taken.
//
// Ports:
//   clk, rst    single rising-edge clock, asynchronous active-high reset
//   bus         stream_lane_packer_if.slave: in_valid/in_ready/in_data/in_lane_en/in_last,
//               out_valid/out_ready/out_data/out_keep/out_last
//   pkt_cnt     (STREAM_PACKER_CNT_EN only) packets handed off downstream, wraps at 2^32
//   byte_cnt    (STREAM_PACKER_CNT_EN only) bytes handed off downstream, wraps at 2^48
//
// Build option: define STREAM_PACKER_CNT_EN to add the pkt_cnt/byte_cnt statistics outputs.
module stream_lane_packer #(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = 128
) (
  input  logic                clk,
  input  logic                rst,
  stream_lane_packer_if.slave bus
`ifdef STREAM_PACKER_CNT_EN
  ,
  output logic [31:0]         pkt_cnt,
  output logic [47:0]         byte_cnt
`endif
);

  localparam int OUT_W  = NUM_LANES * LANE_W;
  localparam int KEEP_W = OUT_W / 8;
  localparam int LANE_B = LANE_W / 8;
  // Wide enough for residue + one full beat (at most 2*NUM_LANES-1 lanes).
  localparam int TW     = $clog2(2 * NUM_LANES);

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] lanes_t;

  // RUN accepts beats; FLUSH owns one pending last-residue beat behind an
  // already-presented full beat and blocks the input meanwhile.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  lanes_t            res_q, res_d;
  lanes_t            out_data_q, out_data_d;
  logic [KEEP_W-1:0] out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic              in_ready;
  logic              accept;
  logic              out_fire;

  logic [TW-1:0]     k;
  logic [TW-1:0]     tot;
  logic [TW-1:0]     pos;
  logic [LANE_W-1:0] merged [2*NUM_LANES];
  lanes_t            lo_lanes;
  lanes_t            hi_lanes;

  // Byte enables for the first 'lanes' lanes, contiguous from bit 0.
  function automatic logic [KEEP_W-1:0] keep_for(input logic [TW-1:0] lanes);
    logic [KEEP_W-1:0] kv;
    kv = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (j < int'(lanes)) kv[j*LANE_B +: LANE_B] = '1;
    end
    return kv;
  endfunction

  // Taking a new beat needs a free output slot: either nothing is presented
  // or the presented beat leaves this very cycle.
  assign in_ready = !rst && (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;

  // Prefix-sum compaction: enabled lane i lands at residue slot
  // cnt + (number of enabled lanes below i). Slots past tot stay zero so
  // unused output lanes and the carried residue are always clean.
  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      k = k + TW'(bus.in_lane_en[i]);
    end
    tot = cnt_q + k;

    for (int p = 0; p < 2*NUM_LANES; p++) begin
      merged[p] = '0;
    end
    for (int p = 0; p < NUM_LANES; p++) begin
      if (TW'(p) < cnt_q) merged[p] = res_q[p];
    end

    pos = cnt_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.in_lane_en[i]) begin
        merged[pos] = bus.in_data[i];
        pos         = pos + TW'(1);
      end
    end

    for (int j = 0; j < NUM_LANES; j++) begin
      lo_lanes[j] = merged[j];
      hi_lanes[j] = merged[j + NUM_LANES];
    end
  end

  // Next-state and next-output decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    // A taken beat is retired unless something below replaces it.
    if (out_fire) out_valid_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (!bus.in_last) begin
            if (tot >= TW'(NUM_LANES)) begin
              out_valid_d = 1'b1;
              out_data_d  = lo_lanes;
              out_keep_d  = '1;
              out_last_d  = 1'b0;
              res_d       = hi_lanes;
              cnt_d       = tot - TW'(NUM_LANES);
            end else begin
              // Not enough for a full beat yet: just absorb into residue.
              res_d = lo_lanes;
              cnt_d = tot;
            end
          end else if (tot <= TW'(NUM_LANES)) begin
            // Whole packet tail fits in one beat; tot == 0 yields the
            // null-byte beat (keep and data all zero) with last set.
            out_valid_d = 1'b1;
            out_data_d  = lo_lanes;
            out_keep_d  = keep_for(tot);
            out_last_d  = 1'b1;
            res_d       = '0;
            cnt_d       = '0;
          end else begin
            // Tail overflows: present a full beat now, keep the remainder
            // for a second last beat once this one is taken.
            out_valid_d = 1'b1;
            out_data_d  = lo_lanes;
            out_keep_d  = '1;
            out_last_d  = 1'b0;
            res_d       = hi_lanes;
            cnt_d       = tot - TW'(NUM_LANES);
            state_d     = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (out_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = res_q;
          out_keep_d  = keep_for(cnt_q);
          out_last_d  = 1'b1;
          res_d       = '0;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      res_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef STREAM_PACKER_CNT_EN
  // Statistics count only what the sink actually took.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      byte_cnt <= '0;
    end else if (out_fire) begin
      if (out_last_q) pkt_cnt <= pkt_cnt + 32'd1;
      byte_cnt <= byte_cnt + 48'($countones(out_keep_q));
    end
  end
`endif

endmodule
